// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI slave byte engine and the register controller.
// master = register controller side, slave = SPI byte engine side.
interface spi_reg_ctrl_if;
  logic [7:0] si_data;
  logic       si_done;
  logic [7:0] so_data;
  logic       so_start;
  logic       so_ready;

  modport master (input si_data, si_done, so_ready, output so_data, so_start);
  modport slave  (output si_data, si_done, so_ready, input so_data, so_start);
endinterface

// File: rtl/spi_reg_ctrl.sv
// Addressed register map over SPI bytes: write 2 cycles and read so_start 3 cycles after si_done rise;
// a read load waits in RD_LOAD while so_ready=0, and cs deassertion abandons any frame.
module spi_reg_ctrl #(
  parameter int         NUM_REGS = 4,
  parameter logic [7:0] REG_RST  = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  spi_reg_ctrl_if.master        bus,
  output logic [8*NUM_REGS-1:0] reg_q,
  input  logic [8*NUM_REGS-1:0] status_in,
  output logic                  wr_stb,
  output logic [6:0]            wr_addr,
  output logic                  frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, WR, RD_LOAD, RD} state_t;

  state_t     state_q, state_d;
  logic       cs_meta_q, cs_s_q;
  logic       si_done_q, si_done_dq;
  logic [6:0] addr_q, addr_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic [7:0] so_data_q, so_data_d;
  logic       so_start_q, so_start_d;
  logic       wr_stb_q, wr_stb_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic       frame_err_q, frame_err_d;

  logic       byte_ev;
  logic       in_rw, in_map;
  logic [7:0] rd_val;

  // si_done is registered before edge detection so the event lines up with the FSM a cycle later.
  assign byte_ev = si_done_q & ~si_done_dq;
  assign in_rw   = 32'(addr_q) < 32'(NUM_REGS);
  assign in_map  = 32'(addr_q) < 32'(2 * NUM_REGS);

  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == 7'(i))            rd_val = regs_q[i];
      if (addr_q == 7'(NUM_REGS + i)) rd_val = status_in[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    so_data_d   = so_data_q;
    so_start_d  = 1'b0;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = frame_err_q;

    // Deselect has priority over any byte event in the same cycle.
    if (state_q != IDLE && cs_s_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (!cs_s_q) state_d = CMD;
        CMD: if (byte_ev) begin
          addr_d      = bus.si_data[6:0];
          frame_err_d = 1'b0;
          state_d     = bus.si_data[7] ? WR : RD_LOAD;
        end
        WR: if (byte_ev) begin
          if (in_rw) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (addr_q == 7'(i)) regs_d[i] = bus.si_data;
            wr_stb_d  = 1'b1;
            wr_addr_d = addr_q;
          end else begin
            frame_err_d = 1'b1;
          end
          addr_d = addr_q + 7'd1;
        end
        RD_LOAD: if (bus.so_ready) begin
          so_data_d  = rd_val;
          so_start_d = 1'b1;
          if (!in_map) frame_err_d = 1'b1;
          state_d    = RD;
        end
        RD: if (byte_ev) begin
          addr_d  = addr_q + 7'd1;
          state_d = RD_LOAD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_meta_q   <= 1'b1;
      cs_s_q      <= 1'b1;
      si_done_q   <= 1'b0;
      si_done_dq  <= 1'b0;
      state_q     <= IDLE;
      addr_q      <= 7'd0;
      so_data_q   <= 8'h00;
      so_start_q  <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= 7'd0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RST;
    end else begin
      cs_meta_q   <= cs;
      cs_s_q      <= cs_meta_q;
      si_done_q   <= bus.si_done;
      si_done_dq  <= si_done_q;
      state_q     <= state_d;
      addr_q      <= addr_d;
      so_data_q   <= so_data_d;
      so_start_q  <= so_start_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[8*i +: 8] = regs_q[i];
  end

  assign bus.so_data  = so_data_q;
  assign bus.so_start = so_start_q;
  assign wr_stb       = wr_stb_q;
  assign wr_addr      = wr_addr_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized frame-level bench: a register-map model queues expected writes/reads, a monitor checks them.
module tb_spi_reg_ctrl;
  localparam int         N   = 4;
  localparam logic [7:0] RST = 8'h00;

  typedef struct {
    int         a;
    logic [7:0] d;
    int         t;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cs = 1'b1;
  logic [8*N-1:0] reg_q;
  logic [8*N-1:0] status_in;
  logic           wr_stb;
  logic [6:0]     wr_addr;
  logic           frame_err;

  spi_reg_ctrl_if bus();

  spi_reg_ctrl #(.NUM_REGS(N), .REG_RST(RST)) dut (
    .clk(clk), .reset(reset), .cs(cs), .bus(bus),
    .reg_q(reg_q), .status_in(status_in),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] mregs [N];
  logic       merr;
  int         maddr;
  logic       mwr;
  exp_t       wq[$];
  exp_t       rq[$];
  logic [7:0] frame_q[$];
  exp_t       me;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8*N-1:0] pack_regs();
    logic [8*N-1:0] p;
    for (int i = 0; i < N; i++) p[8*i +: 8] = mregs[i];
    return p;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply one byte to the model, queue what the DUT should emit, then drive it.
  task automatic send_byte(input logic [7:0] b, input bit first, input bit expect_rd);
    exp_t e;
    @(posedge clk);
    #1;
    if (first) begin
      maddr = int'(b[6:0]);
      mwr   = b[7];
      merr  = 1'b0;
    end else if (mwr) begin
      if (maddr < N) begin
        mregs[maddr] = b;
        e.a = maddr; e.d = b; e.t = cyc + 2;
        wq.push_back(e);
      end else begin
        merr = 1'b1;
      end
      maddr = (maddr + 1) % 128;
    end else begin
      maddr = (maddr + 1) % 128;
    end
    if (!mwr && expect_rd) begin
      e.a = maddr;
      e.t = cyc + 3;
      if (maddr < N)          e.d = mregs[maddr];
      else if (maddr < 2 * N) e.d = status_in[8*(maddr-N) +: 8];
      else begin
        e.d  = 8'h00;
        merr = 1'b1;
      end
      rq.push_back(e);
    end
    bus.si_data = b;
    bus.si_done = 1'b1;
    tick(2);
    bus.si_done = 1'b0;
    tick(8 + $urandom_range(0, 4));
  endtask

  task automatic end_frame();
    tick(3);
    cs = 1'b1;
    tick(5);
    check("frame_err", {31'd0, frame_err}, {31'd0, merr});
    check("reg_q", reg_q, pack_regs());
    check("pending", wq.size() + rq.size(), 0);
  endtask

  task automatic run_frame();
    cs = 1'b0;
    tick(5);
    foreach (frame_q[k]) send_byte(frame_q[k], k == 0, 1'b1);
    end_frame();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (wr_stb) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected actual wr_addr=%0d expected no wr_stb", wr_addr);
        end else begin
          me = wq.pop_front();
          check("wr_addr", {25'd0, wr_addr}, me.a);
          check("wr_data", {24'd0, reg_q[8*me.a +: 8]}, {24'd0, me.d});
          check("wr_cycle", cyc, me.t);
        end
      end
      if (bus.so_start) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected actual so_data=%0h expected no so_start", bus.so_data);
        end else begin
          me = rq.pop_front();
          check("so_data", {24'd0, bus.so_data}, {24'd0, me.d});
          check("so_cycle", cyc, me.t);
          check("so_ready_with_start", {31'd0, bus.so_ready}, 1);
        end
      end
    end
  end

  initial begin
    logic [6:0] ra;
    bit         rw;
    int         nb;

    bus.si_data  = 8'h00;
    bus.si_done  = 1'b0;
    bus.so_ready = 1'b1;
    status_in    = $urandom;
    for (int i = 0; i < N; i++) mregs[i] = RST;
    merr  = 1'b0;
    maddr = 0;
    mwr   = 1'b0;

    tick(3);
    check("rst_reg_q", reg_q, pack_regs());
    check("rst_so_data", {24'd0, bus.so_data}, 0);
    check("rst_so_start", {31'd0, bus.so_start}, 0);
    check("rst_wr_stb", {31'd0, wr_stb}, 0);
    check("rst_wr_addr", {25'd0, wr_addr}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    reset = 1'b1;
    tick(3);

    // Write burst, then read with auto-increment.
    frame_q = '{8'h81, 8'hA5, 8'h3C};
    run_frame();
    frame_q = '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame();
    frame_q = '{8'h02, 8'($urandom), 8'($urandom)};
    run_frame();

    // Status read, then write to a status address.
    status_in[7:0] = 8'h5A;
    frame_q = '{8'h04};
    run_frame();
    frame_q = '{8'h84, 8'hE7};
    run_frame();

    // Out-of-range read, then error cleared by a new command.
    frame_q = '{8'h08};
    run_frame();
    frame_q = '{8'h80, 8'h01};
    run_frame();

    // Backpressured read abandoned by deselect: no so_start may appear.
    bus.so_ready = 1'b0;
    cs = 1'b0;
    tick(5);
    @(posedge clk);
    #1;
    merr = 1'b0;
    bus.si_data = 8'h01;
    bus.si_done = 1'b1;
    tick(2);
    bus.si_done = 1'b0;
    tick(3);
    cs = 1'b1;
    tick(5);
    bus.so_ready = 1'b1;
    tick(3);
    check("abort_frame_err", {31'd0, frame_err}, {31'd0, merr});
    check("abort_pending", wq.size() + rq.size(), 0);
    frame_q = '{8'h83, 8'h9C};
    run_frame();

    // Random frames, including addresses that wrap past 127.
    repeat (25) begin
      ra = ($urandom_range(0, 7) == 0) ? 7'(126 + $urandom_range(0, 1))
                                       : 7'($urandom_range(0, 2 * N + 1));
      rw = 1'($urandom_range(0, 1));
      nb = $urandom_range(0, 3) + (rw ? 1 : 0);
      status_in = $urandom;
      frame_q = {};
      frame_q.push_back({rw, ra});
      for (int k = 0; k < nb; k++) frame_q.push_back(8'($urandom));
      run_frame();
    end

    // Asynchronous reset in the middle of a write burst.
    cs = 1'b0;
    tick(5);
    send_byte(8'h81, 1'b1, 1'b1);
    send_byte(8'hC3, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    for (int i = 0; i < N; i++) mregs[i] = RST;
    merr = 1'b0;
    check("arst_reg_q", reg_q, pack_regs());
    check("arst_frame_err", {31'd0, frame_err}, 0);
    check("arst_wr_addr", {25'd0, wr_addr}, 0);
    check("arst_so_data", {24'd0, bus.so_data}, 0);
    tick(2);
    reset = 1'b1;
    tick(6);
    send_byte(8'h82, 1'b1, 1'b1);
    send_byte(8'h77, 1'b0, 1'b1);
    end_frame();

    check("final_pending", wq.size() + rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
